// File: rtl/ma_wb_skid_reg.sv
// Memory-access to write-back boundary register with a 2-entry skid buffer.
// Handshake: a beat transfers on a rising edge when valid and ready are both high;
// in_ready comes straight from a flop, and out_valid holds its payload stable until consumed.
module ma_wb_skid_reg #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned DEST_W            = 4,
  parameter bit          FLUSH_CLEARS_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] wb_value,
  output logic [1:0]        hz_valid,
  output logic [DEST_W-1:0] hz_dest0,
  output logic [DEST_W-1:0] hz_dest1,
  output logic [1:0]        count
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read_value;
    logic [DEST_W-1:0] dest;
  } payload_t;

  // The state encoding doubles as the occupancy count seen on the count port.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t in_pl;
  logic     in_ready_q, in_ready_d;
  logic     main_valid, skid_valid;
  logic     accept, consume;

  assign in_pl = '{wb_en:          wb_en_in,
                   mem_r_en:       mem_r_en_in,
                   alu_result:     alu_result_in,
                   mem_read_value: mem_read_value_in,
                   dest:           dest_in};

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign accept     = in_valid & in_ready_q;
  assign consume    = main_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    in_ready_d = in_ready_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_pl;
          state_d = ONE;
        end
      end
      ONE: begin
        if (consume && accept) begin
          main_d = in_pl;
        end else if (consume) begin
          state_d = EMPTY;
        end else if (accept) begin
          skid_d  = in_pl;
          state_d = FULL;
        end
      end
      FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards whatever the handshake decided this cycle.
    if (flush) begin
      state_d = EMPTY;
      if (FLUSH_CLEARS_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid;
  assign wb_en          = main_q.wb_en & main_valid;
  assign mem_r_en       = main_q.mem_r_en;
  assign alu_result     = main_q.alu_result;
  assign mem_read_value = main_q.mem_read_value;
  assign dest           = main_q.dest;
  assign wb_value       = main_q.mem_r_en ? main_q.mem_read_value : main_q.alu_result;
  assign hz_valid       = {skid_valid & skid_q.wb_en, main_valid & main_q.wb_en};
  assign hz_dest0       = main_q.dest;
  assign hz_dest1       = skid_q.dest;
  assign count          = 2'(state_q);

endmodule

// File: tb/tb_ma_wb_skid_reg.sv
// Directed bench for ma_wb_skid_reg: a negedge monitor pops expected write-back beats
// from a queue filled on each accepted input, alongside direct status checks.
module tb_ma_wb_skid_reg;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int EW = 2 + 3 * DW + RW;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, wb_en_in, mem_r_en_in, flush;
  logic [DW-1:0] alu_result_in, mem_read_value_in;
  logic [RW-1:0] dest_in;
  logic          out_valid, out_ready, wb_en, mem_r_en;
  logic [DW-1:0] alu_result, mem_read_value, wb_value;
  logic [RW-1:0] dest, hz_dest0, hz_dest1;
  logic [1:0]    hz_valid, count;

  logic [DW-1:0] cur_exp_wbv;
  logic [EW-1:0] exp_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;

  always #5 clk = ~clk;

  ma_wb_skid_reg #(.DATA_W(DW), .DEST_W(RW), .FLUSH_CLEARS_DATA(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .alu_result_in(alu_result_in), .mem_read_value_in(mem_read_value_in),
    .dest_in(dest_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en),
    .alu_result(alu_result), .mem_read_value(mem_read_value),
    .dest(dest), .wb_value(wb_value),
    .hz_valid(hz_valid), .hz_dest0(hz_dest0), .hz_dest1(hz_dest1),
    .count(count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: drive, wait for the edge, settle 1 time unit.
  task automatic step(input logic v, input logic wb, input logic mr,
                      input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                      input logic [RW-1:0] d, input logic [DW-1:0] exp_wbv,
                      input logic ordy, input logic fl, input logic r);
    in_valid          = v;
    wb_en_in          = wb;
    mem_r_en_in       = mr;
    alu_result_in     = alu;
    mem_read_value_in = mem;
    dest_in           = d;
    cur_exp_wbv       = exp_wbv;
    out_ready         = ordy;
    flush             = fl;
    rst               = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  // Monitor: consume check first, then record the accepted input; flush/rst empties the model.
  logic          stall_prev = 1'b0;
  logic [EW-1:0] held_prev;
  logic [EW-1:0] act_bundle;
  logic [EW-1:0] exp_bundle;

  always @(negedge clk) begin
    act_bundle = {wb_en, mem_r_en, alu_result, mem_read_value, dest, wb_value};
    if (stall_prev) chk("stall_stable", 128'(act_bundle), 128'(held_prev));
    if (rst === 1'b1 || flush === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(act_bundle), 128'(0));
        end else begin
          exp_bundle = exp_q.pop_front();
          chk("wb_beat", 128'(act_bundle), 128'(exp_bundle));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({wb_en_in, mem_r_en_in, alu_result_in, mem_read_value_in,
                         dest_in, cur_exp_wbv});
    end
    stall_prev = out_valid && !out_ready && rst !== 1'b1 && flush !== 1'b1;
    held_prev  = act_bundle;
  end

  initial begin
    in_valid = 0; wb_en_in = 0; mem_r_en_in = 0; alu_result_in = '0;
    mem_read_value_in = '0; dest_in = '0; cur_exp_wbv = '0;
    out_ready = 0; flush = 0; rst = 1;
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_wb_value", 128'(wb_value), 128'(0));
    chk("rst_hz", 128'({hz_valid, hz_dest0, hz_dest1}), 128'(0));

    // Single transfer, load selects the memory value.
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'hAA, 4'd3, 32'hAA, 1'b1, 1'b0, 1'b0);
    chk("single_out_valid", 128'(out_valid), 128'(1));
    chk("single_wb_value", 128'(wb_value), 128'(32'hAA));
    chk("single_dest", 128'(dest), 128'(3));
    chk("single_wb_en", 128'(wb_en), 128'(1));
    chk("single_count", 128'(count), 128'(1));
    idle(1'b1);
    chk("single_drained", 128'(count), 128'(0));

    // Streaming 1..4 with write-back always ready.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'(i), 32'hF0 + 32'(i), 4'(i), 32'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      chk("stream_count", 128'(count), 128'(1));
      chk("stream_alu", 128'(alu_result), 128'(i));
    end
    idle(1'b1);
    chk("stream_drained", 128'(count), 128'(0));

    // Stall fill with A then B.
    step(1'b1, 1'b1, 1'b0, 32'd5, 32'h1, 4'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd6, 32'h2, 4'd6, 32'd6, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 128'(count), 128'(2));
    chk("fill_in_ready", 128'(in_ready), 128'(0));
    chk("fill_alu", 128'(alu_result), 128'(5));
    chk("fill_hz_valid", 128'(hz_valid), 128'(2'b11));
    chk("fill_hz_dest", 128'({hz_dest0, hz_dest1}), 128'({4'd5, 4'd6}));
    idle(1'b0);
    chk("fill_hold_alu", 128'(alu_result), 128'(5));
    idle(1'b1);
    chk("release_count", 128'(count), 128'(1));
    chk("release_in_ready", 128'(in_ready), 128'(1));
    chk("release_alu", 128'(alu_result), 128'(6));
    idle(1'b1);
    chk("release_drained", 128'(count), 128'(0));

    // Non-writing entry.
    step(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd7, 32'h77, 1'b0, 1'b0, 1'b0);
    chk("nowb_out_valid", 128'(out_valid), 128'(1));
    chk("nowb_wb_en", 128'(wb_en), 128'(0));
    chk("nowb_hz_valid", 128'(hz_valid), 128'(2'b00));
    chk("nowb_hz_dest0", 128'(hz_dest0), 128'(7));
    idle(1'b1);

    // Flush while FULL with a same-cycle push.
    step(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'd12, 32'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hD, 32'hDD, 4'd13, 32'hDD, 1'b0, 1'b0, 1'b0);
    chk("preflush_count", 128'(count), 128'(2));
    step(1'b1, 1'b1, 1'b0, 32'hE, 32'h0, 4'd14, 32'hE, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_payload", 128'({alu_result, mem_read_value, dest, hz_dest1}), 128'(0));
    idle(1'b1);
    chk("flush_no_capture", 128'(out_valid), 128'(0));

    // Reset mid-stall, then a normal push right after.
    step(1'b1, 1'b1, 1'b0, 32'h31, 32'h0, 4'd1, 32'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h32, 32'h0, 4'd2, 32'h32, 1'b0, 1'b0, 1'b0);
    chk("prerst_count", 128'(count), 128'(2));
    step(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 4'd3, 32'h33, 1'b1, 1'b0, 1'b1);
    chk("midrst_status", 128'({out_valid, in_ready, count, hz_valid}), 128'({1'b0, 1'b1, 2'd0, 2'd0}));
    chk("midrst_payload", 128'({wb_en, mem_r_en, alu_result, mem_read_value, dest, wb_value, hz_dest0, hz_dest1}), 128'(0));
    step(1'b1, 1'b1, 1'b1, 32'h55, 32'h66, 4'd9, 32'h66, 1'b1, 1'b0, 1'b0);
    chk("postrst_out_valid", 128'(out_valid), 128'(1));
    chk("postrst_wb_value", 128'(wb_value), 128'(32'h66));
    idle(1'b1);
    chk("postrst_drained", 128'(count), 128'(0));
    idle(1'b1);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ma_wb_skid_reg.md
Name: ma_wb_skid_reg

Overview:
- Parametrised memory-access to write-back pipeline boundary register for the ARM pipeline.
- Carries wb_en, mem_r_en, ALU result, memory read value and destination register across the stage boundary.
- Adds a valid/ready handshake with a 2-entry skid buffer so a stalled write-back never drops an instruction, plus a flush.
- Computes the selected write-back value and exposes hazard-visible destinations of both held entries to the forwarding/hazard unit.

Parameters:
DATA_W, 32, width of alu_result, mem_read_value and wb_value
DEST_W, 4, width of destination register index
FLUSH_CLEARS_DATA, 1, 1: flush also zeroes payload registers; 0: flush clears valid bits only

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream holds a valid MA result
in_ready  out  1  block can accept this cycle (registered)
wb_en_in  in  1  instruction writes the register file
mem_r_en_in  in  1  instruction is a load
alu_result_in  in  DATA_W  ALU result / address
mem_read_value_in  in  DATA_W  data memory read value
dest_in  in  DEST_W  destination register index
flush  in  1  discard all held entries
out_valid  out  1  main entry valid
out_ready  in  1  write-back consumes main entry this cycle
wb_en  out  1  main_wb_en AND out_valid
mem_r_en  out  1  main entry load flag
alu_result  out  DATA_W  main entry ALU result
mem_read_value  out  DATA_W  main entry memory value
dest  out  DEST_W  main entry destination
wb_value  out  DATA_W  mem_r_en ? mem_read_value : alu_result (combinational from main)
hz_valid  out  2  bit0: main holds valid wb_en=1 entry; bit1: same for skid entry
hz_dest0  out  DEST_W  main entry dest
hz_dest1  out  DEST_W  skid entry dest
count  out  2  entries held (0..2)

Behaviour:
- Storage: main entry (feeds outputs) and skid entry; each has a valid bit plus payload {wb_en, mem_r_en, alu_result, mem_read_value, dest}.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = NOT skid_valid, driven from a register; never depends combinationally on out_ready.
- State EMPTY (count 0):
  - accept -> load main; next state ONE.
- State ONE (count 1):
  - consume & accept -> main replaced by input; stay ONE.
  - consume & !accept -> EMPTY.
  - !consume & accept -> input to skid; next state FULL; in_ready=0 next cycle.
  - neither -> hold.
- State FULL (count 2), in_ready=0:
  - consume -> skid moves to main; next state ONE; in_ready=1 next cycle.
  - otherwise hold.
- Ordering strictly FIFO; zero-latency bypass not provided. Latency input to output is 1 cycle when empty.
- Stall stability: while out_valid & !out_ready, all main outputs are held bit-stable.
- Flush:
  - Next edge clears both valid bits; count=0, in_ready=1.
  - Any same-cycle accept or consume is discarded; flush wins.
  - Payload is zeroed when FLUSH_CLEARS_DATA=1.
- rst: same effect as flush plus forced payload zeroing regardless of parameter.
  - Reset values: out_valid=0, in_ready=1, wb_en=0, mem_r_en=0, alu_result=0, mem_read_value=0, dest=0, wb_value=0, hz_valid=0, hz_dest0=0, hz_dest1=0, count=0.
  - rst overrides flush and all handshake activity, including mid-stall.
- Payload is never qualified except wb_en and hz_valid, which are ANDed with their entry's valid bit.
- hz_destN outputs show the stored dest even when invalid; consumers qualify them with hz_valid.

Test Plan:
- Reset then single transfer: in_valid=1 with alu=0x10, mem=0xAA, mem_r_en=1, dest=3, out_ready=1 -> next cycle out_valid=1, wb_value=0xAA, dest=3, wb_en=1, count=1.
- Back-to-back streaming with out_ready=1, inputs 1,2,3,4 -> outputs 1,2,3,4 on consecutive cycles; in_ready stays 1; count stays 1.
- Stall fill: out_ready=0, push A (alu=5) then B (alu=6) -> count=2, in_ready=0, alu_result=5 held stable, hz_valid=2'b11, hz_dest1=B.dest. Release out_ready -> A then B appear; in_ready returns to 1 one cycle after A is consumed.
- Non-writing entry: wb_en_in=0, dest=7 -> out_valid=1, wb_en=0, hz_valid[0]=0.
- Flush while FULL, with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1; input not captured; payload 0 when FLUSH_CLEARS_DATA=1.
- rst asserted mid-stall with count=2 -> all outputs at reset values on next edge; a push immediately after rst deasserts is delivered normally.
